countdown_timer: RTL and testbench

- Loadable down-counter with terminal-count signalling; the counterpart to the free-running up-counter (`clk`/`rst`/`en`/`count`).
- Software or an upstream FSM loads a start value. The block decrements on each enabled cycle and flags expiry.
- Supports one-shot and auto-reload (periodic tick) modes.
- Used as the timeout/period generator beside the up-counter in the same clock domain.

---
 rtl/countdown_timer_pkg.sv | 20 ++
 rtl/countdown_timer.sv | 100 ++++++++++
 tb/tb_countdown_timer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// ============================================================================
// Module   : countdown_timer_pkg
// Brief    : Shared FSM state encoding and default counter width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package countdown_timer_pkg;

  localparam int c_width_default = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down-counter with one-shot / auto-reload modes and tc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             r_done;
  logic             w_done_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_count  <= c_zero;
      r_reload <= c_zero;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    w_done_nxt   = r_done;

    // A load overrides any terminal-cycle action, so no tc/done on that edge.
    if (load) begin
      w_count_nxt  = load_val;
      w_reload_nxt = load_val;
      w_done_nxt   = 1'b0;
      w_state_nxt  = (load_val != c_zero) ? RUN : IDLE;
    end else begin
      case (r_state)
        RUN: begin
          if (en) begin
            if (r_count == c_one) begin
              w_tc_nxt = 1'b1;
              if (auto_reload) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = c_zero;
                w_done_nxt  = 1'b1;
                w_state_nxt = DONE;
              end
            end else if (r_count > c_one) begin
              w_count_nxt = r_count - c_one;
            end
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  assign count = r_count;
  assign busy  = (r_state == RUN);
  assign tc    = r_tc;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Directed self-checking bench for countdown_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       auto_reload;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic b,
                         input logic t, input logic d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  logic [3:0] per_cnt [12] = '{4'd3, 4'd2, 4'd1, 4'd4, 4'd3, 4'd2, 4'd1, 4'd4, 4'd3, 4'd2, 4'd1, 4'd4};
  logic       per_tc  [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       pau_en  [5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] pau_cnt [5]  = '{4'd4, 4'd3, 4'd3, 4'd3, 4'd2};

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'd0; auto_reload = 1'b0;
    #12;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_all("idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // One-shot from 3
    load = 1'b1; load_val = 4'd3; en = 1'b1; auto_reload = 1'b0;
    tick();
    chk_all("os_load", 4'd3, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    chk_all("os_2", 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("os_1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("os_0", 4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("os_hold", 4'd0, 1'b0, 1'b0, 1'b1);
    end

    // Periodic from 4
    load = 1'b1; load_val = 4'd4; auto_reload = 1'b1; en = 1'b1;
    tick();
    chk_all("per_load", 4'd4, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all("per", per_cnt[i], 1'b1, per_tc[i], 1'b0);
    end

    // Pause
    load = 1'b1; load_val = 4'd5; auto_reload = 1'b0; en = 1'b1;
    tick();
    chk_all("pau_load", 4'd5, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = pau_en[i];
      tick();
      chk_all("pau", pau_cnt[i], 1'b1, 1'b0, 1'b0);
    end

    // Load in the terminal cycle wins
    en = 1'b1;
    tick();
    chk_all("pri_1", 4'd1, 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'd7;
    tick();
    chk_all("pri_load7", 4'd7, 1'b1, 1'b0, 1'b0);
    load_val = 4'd0;
    tick();
    chk_all("pri_load0", 4'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    chk_all("pri_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Reload value 1 in periodic mode
    load = 1'b1; load_val = 4'd1; auto_reload = 1'b1; en = 1'b1;
    tick();
    chk_all("one_load", 4'd1, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("one", 4'd1, 1'b1, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-count
    load = 1'b1; load_val = 4'd5; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    chk_all("ar_pre", 4'd5, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("ar_async", 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    tick();
    chk_all("ar_after", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
